// File: rtl/mux4_sched_pkg.sv
// Shared constants, lock-state encoding and a one-hot helper for the 4-way
// round-robin capture scheduler.
package mux4_sched_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping modulo 4.
module rr_pick4
  import mux4_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);

  logic [SEL_W-1:0] cand_s;

  // Walk from the farthest offset down so the nearest-to-ptr request wins.
  always_comb begin
    idx_o   = 2'd0;
    found_o = 1'b0;
    cand_s  = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_s = ptr_i + SEL_W'(k);
      if (req_i[cand_s]) begin
        idx_o   = cand_s;
        found_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        found_o = found_o;
      end
    end
  end

  assign onehot_o = found_o ? idx_to_onehot(idx_o) : 4'b0000;

endmodule

// File: rtl/mux4_rr_sched.sv
// 4-input round-robin capture mux with a one-word registered output stage.
// Optional burst lock (req_last port) is built when MUX4_SCHED_LOCK_EN is defined.
module mux4_rr_sched
  import mux4_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] din,
`ifdef MUX4_SCHED_LOCK_EN
  input  logic [N_REQ-1:0]        req_last,
`endif
  output logic [N_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_src
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  src_q, src_d;

  logic [N_REQ-1:0]  elig_s;
  logic [N_REQ-1:0]  pick_oh_s;
  logic [SEL_W-1:0]  pick_idx_s;
  logic              pick_found_s;
  logic              capture_s;

`ifdef MUX4_SCHED_LOCK_EN
  lock_state_e       lock_q, lock_d;
  logic [SEL_W-1:0]  owner_q, owner_d;

  // While locked, only the burst owner may be picked.
  always_comb begin
    if (lock_q == LOCK_LOCKED) begin
      elig_s = req & idx_to_onehot(owner_q);
    end else begin
      elig_s = req;
    end
  end
`else
  assign elig_s = req;
`endif

  rr_pick4 u_pick (
    .req_i    (elig_s),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh_s),
    .idx_o    (pick_idx_s),
    .found_o  (pick_found_s)
  );

  // Reset gates capture so gnt/sel read zero while areset_n is low.
  assign capture_s = areset_n && (!valid_q || out_ready) && pick_found_s;
  assign gnt       = capture_s ? pick_oh_s  : 4'b0000;
  assign sel       = capture_s ? pick_idx_s : 2'd0;

  // Output stage: replace on capture, clear on drain, otherwise hold.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (capture_s) begin
      ptr_d   = pick_idx_s + 2'd1;
      valid_d = 1'b1;
      data_d  = din[int'(pick_idx_s)*DATA_W +: DATA_W];
      src_d   = pick_idx_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

`ifdef MUX4_SCHED_LOCK_EN
  // Burst lock: a non-final word locks onto its requester, the final word releases.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    case (lock_q)
      LOCK_UNLOCKED: begin
        if (capture_s && !req_last[pick_idx_s]) begin
          lock_d  = LOCK_LOCKED;
          owner_d = pick_idx_s;
        end else begin
          lock_d  = LOCK_UNLOCKED;
        end
      end
      LOCK_LOCKED: begin
        if (capture_s && req_last[pick_idx_s]) begin
          lock_d = LOCK_UNLOCKED;
        end else begin
          lock_d = LOCK_LOCKED;
        end
      end
      default: begin
        lock_d  = LOCK_UNLOCKED;
        owner_d = 2'd0;
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      lock_q  <= LOCK_UNLOCKED;
      owner_q <= 2'd0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`endif

  // Pointer and output register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 2'd0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Table-driven self-checking bench for mux4_rr_sched with a capture scoreboard;
// the burst-lock vectors run only when MUX4_SCHED_LOCK_EN is defined.
module tb_mux4_rr_sched;

  localparam int DATA_W = 8;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic [7:0] d2;
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    logic       exp_valid;
    logic       exp_hold;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] src;
  } word_t;

  logic                    clk;
  logic                    areset_n;
  logic [3:0]              req;
  logic [3:0]              req_last;
  logic [4*DATA_W-1:0]     din;
  logic [3:0]              gnt;
  logic [1:0]              sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [1:0]              out_src;

  logic [7:0] din_w [4];
  word_t      sb_q [$];
  word_t      last_w;
  vec_t       vt [$];
  vec_t       lk [$];
  int         checks;
  int         failures;

  assign din = {din_w[3], din_w[2], din_w[1], din_w[0]};

  mux4_rr_sched #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .req       (req),
    .din       (din),
`ifdef MUX4_SCHED_LOCK_EN
    .req_last  (req_last),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int idx, input vec_t v);
    word_t w;
    req       = v.req;
    req_last  = v.last;
    out_ready = v.rdy;
    din_w[2]  = v.d2;
    @(negedge clk);
    chk({tag, "_gnt"}, idx, 32'(gnt), 32'(v.exp_gnt));
    chk({tag, "_sel"}, idx, 32'(sel), 32'(v.exp_sel));
    if (v.exp_gnt != 4'b0000) begin
      w.data = din_w[v.exp_sel];
      w.src  = v.exp_sel;
      sb_q.push_back(w);
    end
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, idx, 32'(out_valid), 32'(v.exp_valid));
    if (v.exp_gnt != 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, idx, 32'd0, 32'd1);
      end else begin
        w = sb_q.pop_front();
        chk({tag, "_data"}, idx, 32'(out_data), 32'(w.data));
        chk({tag, "_src"},  idx, 32'(out_src),  32'(w.src));
        last_w = w;
      end
    end else if (v.exp_hold) begin
      chk({tag, "_hold_data"}, idx, 32'(out_data), 32'(last_w.data));
      chk({tag, "_hold_src"},  idx, 32'(out_src),  32'(last_w.src));
    end
  endtask

  // Async reset pulse mid-cycle: outputs must clear before any clock edge.
  task automatic reset_pulse(input int idx);
    #2;
    req       = 4'b1111;
    out_ready = 1'b1;
    areset_n  = 1'b0;
    #1;
    chk("rst_valid", idx, 32'(out_valid), 32'd0);
    chk("rst_data",  idx, 32'(out_data),  32'd0);
    chk("rst_src",   idx, 32'(out_src),   32'd0);
    chk("rst_gnt",   idx, 32'(gnt),       32'd0);
    chk("rst_sel",   idx, 32'(sel),       32'd0);
    sb_q.delete();
    last_w.data = 8'h00;
    last_w.src  = 2'd0;
    @(posedge clk);
    #1;
    areset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic rd,
                              input logic [7:0] d2, input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic h);
    vec_t x;
    x.req = r; x.last = l; x.rdy = rd; x.d2 = d2;
    x.exp_gnt = g; x.exp_sel = s; x.exp_valid = v; x.exp_hold = h;
    return x;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    din_w[0] = 8'h10; din_w[1] = 8'h21; din_w[2] = 8'h32; din_w[3] = 8'h43;
    last_w.data = 8'h00;
    last_w.src  = 2'd0;

    // Idle, then four requests held: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) vt.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'h32, 4'b0000, 2'd0, 1'b0, 1'b0));
    vt.push_back(mk(4'b1111, 4'b0000, 1'b1, 8'h32, 4'b0001, 2'd0, 1'b1, 1'b0));
    vt.push_back(mk(4'b1111, 4'b0000, 1'b1, 8'h32, 4'b0010, 2'd1, 1'b1, 1'b0));
    vt.push_back(mk(4'b1111, 4'b0000, 1'b1, 8'h32, 4'b0100, 2'd2, 1'b1, 1'b0));
    vt.push_back(mk(4'b1111, 4'b0000, 1'b1, 8'h32, 4'b1000, 2'd3, 1'b1, 1'b0));
    vt.push_back(mk(4'b1111, 4'b0000, 1'b1, 8'h32, 4'b0001, 2'd0, 1'b1, 1'b0));
    vt.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'h32, 4'b0000, 2'd0, 1'b0, 1'b1));
    // Backpressure on 0xA5, then wrap from ptr=3 to requester 3 then 0.
    vt.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'hA5, 4'b0100, 2'd2, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(4'b1001, 4'b0000, 1'b0, 8'hA5, 4'b0000, 2'd0, 1'b1, 1'b1));
    vt.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'hA5, 4'b1000, 2'd3, 1'b1, 1'b0));
    vt.push_back(mk(4'b0001, 4'b0000, 1'b1, 8'hA5, 4'b0001, 2'd0, 1'b1, 1'b0));
    vt.push_back(mk(4'b1011, 4'b0000, 1'b1, 8'hA5, 4'b0010, 2'd1, 1'b1, 1'b0));
    vt.push_back(mk(4'b1001, 4'b0000, 1'b1, 8'hA5, 4'b1000, 2'd3, 1'b1, 1'b0));
    vt.push_back(mk(4'b0000, 4'b0000, 1'b0, 8'hA5, 4'b0000, 2'd0, 1'b1, 1'b1));
    vt.push_back(mk(4'b0000, 4'b0000, 1'b1, 8'hA5, 4'b0000, 2'd0, 1'b0, 1'b1));

    // Burst from requester 1 (last on third word) while requester 2 waits.
    lk.push_back(mk(4'b0110, 4'b0000, 1'b1, 8'h32, 4'b0010, 2'd1, 1'b1, 1'b0));
    lk.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'h32, 4'b0000, 2'd0, 1'b0, 1'b1));
    lk.push_back(mk(4'b0110, 4'b0000, 1'b1, 8'h32, 4'b0010, 2'd1, 1'b1, 1'b0));
    lk.push_back(mk(4'b0110, 4'b0010, 1'b1, 8'h32, 4'b0010, 2'd1, 1'b1, 1'b0));
    lk.push_back(mk(4'b0100, 4'b0000, 1'b1, 8'h32, 4'b0100, 2'd2, 1'b1, 1'b0));
    lk.push_back(mk(4'b0010, 4'b0000, 1'b1, 8'h32, 4'b0010, 2'd1, 1'b1, 1'b0));

    req       = 4'b1111;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    areset_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_valid", 0, 32'(out_valid), 32'd0);
    chk("init_data",  0, 32'(out_data),  32'd0);
    chk("init_src",   0, 32'(out_src),   32'd0);
    chk("init_gnt",   0, 32'(gnt),       32'd0);
    chk("init_sel",   0, 32'(sel),       32'd0);
    req = 4'b0000;
    @(posedge clk);
    #1;
    areset_n = 1'b1;

    foreach (vt[i]) run_vec("tbl", i, vt[i]);

    // Mid-transfer reset: pending word discarded, ptr back to 0.
    run_vec("pre_rst", 0, mk(4'b0010, 4'b0000, 1'b0, 8'hA5, 4'b0010, 2'd1, 1'b1, 1'b0));
    reset_pulse(1);
    run_vec("post_rst", 0, mk(4'b1111, 4'b0000, 1'b1, 8'hA5, 4'b0001, 2'd0, 1'b1, 1'b0));

`ifdef MUX4_SCHED_LOCK_EN
    din_w[2] = 8'h32;
    foreach (lk[i]) run_vec("lock", i, lk[i]);
    reset_pulse(2);
    run_vec("unlock_rst", 0, mk(4'b0100, 4'b0000, 1'b1, 8'h32, 4'b0100, 2'd2, 1'b1, 1'b0));
`endif

    chk("sb_drained", 0, 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sched.md
MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

Interface
REQ-001 Parameter: DATA_W, default 8, width of each requester's data word.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: areset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req  input  4  per-requester request; requester i holds req[i] and its data stable until gnt[i].
REQ-005 Port: din  input  4*DATA_W  requester data, requester i in bits [i*DATA_W +: DATA_W].
REQ-006 Port: gnt  output  4  one-hot acknowledge, combinational, high in the cycle requester i's data is captured.
REQ-007 Port: sel  output  2  mux select, combinational index of the current winner, 0 when no capture occurs.
REQ-008 Port: out_valid  output  1  registered output holds a valid word.
REQ-009 Port: out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-010 Port: out_data  output  DATA_W  registered captured word.
REQ-011 Port: out_src  output  2  registered index of the requester that supplied out_data.
REQ-012 Port (only with MUX4_SCHED_LOCK_EN): req_last  input  4  high with req[i] marks the final word of requester i's burst.

Function
REQ-013 Capture condition: capture occurs in a cycle when (!out_valid || out_ready) and |req is true.
REQ-014 Winner: first i with req[i]=1, searching ptr, ptr+1, ... modulo 4.
REQ-015 On capture: gnt[winner]=1, sel=winner, next edge loads out_data=din[winner], out_src=winner, out_valid=1, ptr=(winner+1) mod 4, so 3 wraps to 0.
REQ-016 Latency: word appears on out_data one cycle after its gnt pulse.
REQ-017 Throughput: one word per cycle when out_ready stays high; simultaneous drain and capture in one cycle replaces the word with out_valid held at 1.
REQ-018 Drain without capture: out_valid clears on the next edge; out_data and out_src keep their last values.
REQ-019 Backpressure: while out_valid=1 and out_ready=0, gnt=0, and out_data, out_src and ptr are held.
REQ-020 No request: gnt=0, sel=0, ptr unchanged.
REQ-021 Fairness: with all four requests held continuously, grants rotate in strict order, each requester served once per 4 captures.

Reset
REQ-022 While areset_n=0: out_valid=0, out_data=0, out_src=0, ptr=0, lock state UNLOCKED; gnt and sel evaluate to 0 because no capture is allowed.
REQ-023 Mid-transfer reset: a pending out_valid word is discarded without handshake, and any lock is released.
REQ-024 First capture can occur in the first rising edge after areset_n deasserts.

Configuration
REQ-025 Macro MUX4_SCHED_LOCK_EN defined: burst lock FSM is present, with states UNLOCKED and LOCKED(owner).
- UNLOCKED -> LOCKED(i): capture from i with req_last[i]=0.
- In LOCKED(i): only requester i is eligible, regardless of other requests; if req[i]=0, no capture occurs.
- LOCKED(i) -> UNLOCKED: capture from i with req_last[i]=1; ptr then becomes (i+1) mod 4.
REQ-026 Macro not defined: req_last port and lock FSM are absent, and every capture is arbitrated per REQ-014.

Structure
REQ-027 Package mux4_sched_pkg: N_REQ=4, SEL_W=2, lock state enum.
REQ-028 Sub-module rr_pick4: combinational rotating-priority picker (inputs req and ptr; outputs one-hot and index); no other sub-modules.

Verification
REQ-029 Reset, then req=4'b0000 for 5 cycles -> out_valid=0, gnt=0, sel=0 throughout.
REQ-030 out_ready=1, req=4'b1111 held, din words 0x10/0x21/0x32/0x43 -> gnt sequence 0001,0010,0100,1000,0001 and out_src 0,1,2,3,0, one word per cycle.
REQ-031 Backpressure: req=4'b0100 with din2=0xA5 captured, out_ready=0 for 3 cycles -> out_data=0xA5 held, gnt=0; out_ready=1 -> drained next edge.
REQ-032 Wrap: ptr=3, req=4'b1001 -> requester 3 granted, then requester 0; ptr returns to 1.
REQ-033 Lock (macro on): requester 1 sends 3 words with req_last=0,0,1 while req[2] is held -> gnt[2] only after the third word of requester 1.
REQ-034 areset_n pulsed low while out_valid=1 and LOCKED -> out_valid=0, ptr=0, UNLOCKED immediately, without waiting for a clock edge.
